// File: rtl/sfr_write_arbiter_if.sv
// sfr_write_arbiter_if: requester bus plus shared SFR write port of the arbiter
interface sfr_write_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 64,
    parameter int N_SFR  = 14
);
    logic [N_REQ-1:0]        req_valid;
    logic [32*N_REQ-1:0]     req_addr;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        req_err;
    logic [N_SFR-1:0]        sfr_load;
    logic [DATA_W-1:0]       sfr_data;
    logic                    busy;
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ack, req_err, sfr_load, sfr_data, busy
    );
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ack, req_err, sfr_load, sfr_data, busy
    );
endinterface

// File: rtl/sfr_write_arbiter.sv
// sfr_write_arbiter: round-robin arbitration of SFR writes with one-hot decoded,
// flop-driven load strobe held for a full cycle around the SFR capture (falling) edge.
module sfr_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 64,
    parameter int N_SFR  = 14
) (
    input logic clk_i,
    input logic rst_ni,
    sfr_write_arbiter_if.slave bus_if
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic {IDLE, WRITE} state_t;
    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d, win;
    logic [N_SFR-1:0]  load_q, load_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d, err_q, err_d;
    logic [31:0]       addr;
    logic [11:0]       idx;
    logic              found, hit;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= IW'(N_REQ - 1);
            load_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            load_q  <= load_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end
    // Search starts just after the previous winner so every waiter is reached within N_REQ grants.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int o = 1; o <= N_REQ; o++) begin
            if (!found && bus_if.req_valid[(int'(last_q) + o) % N_REQ]) begin
                win   = IW'((int'(last_q) + o) % N_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        addr    = bus_if.req_addr[32*win +: 32];
        idx     = addr[31:20];
        hit     = (addr[19:0] == 20'd0) && (idx >= 12'd1) && (idx <= 12'(N_SFR));
        state_d = IDLE;
        last_d  = last_q;
        load_d  = '0;
        data_d  = data_q;
        ack_d   = '0;
        err_d   = '0;
        if (state_q == IDLE && found) begin
            state_d    = WRITE;
            last_d     = win;
            load_d     = hit ? N_SFR'(1) << (idx - 12'd1) : '0;
            data_d     = bus_if.req_data[DATA_W*win +: DATA_W];
            ack_d[win] = 1'b1;
            err_d[win] = !hit;
        end
    end
    assign bus_if.sfr_load = load_q;
    assign bus_if.sfr_data = data_q;
    assign bus_if.req_ack  = ack_q;
    assign bus_if.req_err  = err_q;
    assign bus_if.busy     = (state_q == WRITE);
endmodule
